// File: rtl/decode_stage.sv
// LC-3b decode stage: DE latch, control store addressing, register dependency
// check and the AGEX latch that is loaded alongside the registered cs_bits.
module decode_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fe_valid,
  input  logic [DATA_W-1:0]   fe_ir,
  input  logic [DATA_W-1:0]   fe_npc,
  input  logic                mem_stall,
  input  logic                flush,
  input  logic [DATA_W-1:0]   sr1_data,
  input  logic [DATA_W-1:0]   sr2_data,
  input  logic                agex_ld_reg_v,
  input  logic                mem_ld_reg_v,
  input  logic                sr_ld_reg_v,
  input  logic [REG_ID_W-1:0] agex_dr_id,
  input  logic [REG_ID_W-1:0] mem_dr_id,
  input  logic [REG_ID_W-1:0] sr_dr_id,
  output logic [5:0]          cs_addr,
  output logic [REG_ID_W-1:0] sr1_id,
  output logic [REG_ID_W-1:0] sr2_id,
  output logic                de_stall,
  output logic                de_br_stall,
  output logic                agex_valid,
  output logic [DATA_W-1:0]   agex_ir,
  output logic [DATA_W-1:0]   agex_npc,
  output logic [DATA_W-1:0]   agex_sr1,
  output logic [DATA_W-1:0]   agex_sr2,
  output logic [REG_ID_W-1:0] agex_drid
);

  logic                de_valid;
  logic [DATA_W-1:0]   de_ir;
  logic [DATA_W-1:0]   de_npc;

  logic [3:0]          op;
  logic                is_store;
  logic                is_alu;
  logic                uses1;
  logic                uses2;
  logic                hit1;
  logic                hit2;
  logic                dep_stall;
  logic [REG_ID_W-1:0] drid;

  always_comb begin
    op       = de_ir[15:12];
    is_store = (op == 4'b0011) || (op == 4'b0111) || (op == 4'b1011);
    is_alu   = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1001);

    uses1 = 1'b0;
    case (op)
      4'b0001, 4'b0101, 4'b1001, 4'b1101,
      4'b0010, 4'b0110, 4'b1010,
      4'b0011, 4'b0111, 4'b1011,
      4'b1100: uses1 = 1'b1;
      4'b0100: uses1 = ~de_ir[11];
      default: uses1 = 1'b0;
    endcase
    uses2 = is_store | (is_alu & ~de_ir[5]);

    sr1_id = REG_ID_W'(de_ir[8:6]);
    sr2_id = is_store ? REG_ID_W'(de_ir[11:9]) : REG_ID_W'(de_ir[2:0]);
    drid   = (op == 4'b0100) ? REG_ID_W'(3'd7) : REG_ID_W'(de_ir[11:9]);

    hit1 = (agex_ld_reg_v && (agex_dr_id == sr1_id)) ||
           (mem_ld_reg_v  && (mem_dr_id  == sr1_id)) ||
           (sr_ld_reg_v   && (sr_dr_id   == sr1_id));
    hit2 = (agex_ld_reg_v && (agex_dr_id == sr2_id)) ||
           (mem_ld_reg_v  && (mem_dr_id  == sr2_id)) ||
           (sr_ld_reg_v   && (sr_dr_id   == sr2_id));

    dep_stall   = de_valid & ((uses1 & hit1) | (uses2 & hit2));
    de_stall    = dep_stall | mem_stall;
    de_br_stall = de_valid & ((op == 4'b0000) || (op == 4'b0100) ||
                              (op == 4'b1100) || (op == 4'b1111));
    cs_addr     = {op, de_ir[11], de_ir[5]};
  end

  // DE latch: flush only drops valid so cs_addr stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_valid <= 1'b0;
      de_ir    <= '0;
      de_npc   <= '0;
    end else if (flush) begin
      de_valid <= 1'b0;
    end else if (!de_stall) begin
      de_valid <= fe_valid;
      de_ir    <= fe_ir;
      de_npc   <= fe_npc;
    end
  end

  // AGEX latch: a dependency stall without mem_stall issues a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agex_valid <= 1'b0;
      agex_ir    <= '0;
      agex_npc   <= '0;
      agex_sr1   <= '0;
      agex_sr2   <= '0;
      agex_drid  <= '0;
    end else if (flush) begin
      agex_valid <= 1'b0;
    end else if (!mem_stall) begin
      agex_valid <= de_valid & ~dep_stall;
      agex_ir    <= de_ir;
      agex_npc   <= de_npc;
      agex_sr1   <= sr1_data;
      agex_sr2   <= sr2_data;
      agex_drid  <= drid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model derived from the decode rules.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        fe_valid;
  logic [15:0] fe_ir;
  logic [15:0] fe_npc;
  logic        mem_stall;
  logic        flush;
  logic [15:0] sr1_data;
  logic [15:0] sr2_data;
  logic        agex_ld_reg_v;
  logic        mem_ld_reg_v;
  logic        sr_ld_reg_v;
  logic [2:0]  agex_dr_id;
  logic [2:0]  mem_dr_id;
  logic [2:0]  sr_dr_id;
  logic [5:0]  cs_addr;
  logic [2:0]  sr1_id;
  logic [2:0]  sr2_id;
  logic        de_stall;
  logic        de_br_stall;
  logic        agex_valid;
  logic [15:0] agex_ir;
  logic [15:0] agex_npc;
  logic [15:0] agex_sr1;
  logic [15:0] agex_sr2;
  logic [2:0]  agex_drid;

  int tests;
  int fails;

  // reference model state
  logic        m_dv;
  logic [15:0] m_dir;
  logic [15:0] m_dnpc;
  logic        m_av;
  logic [15:0] m_air;
  logic [15:0] m_anpc;
  logic [15:0] m_asr1;
  logic [15:0] m_asr2;
  logic [2:0]  m_adr;

  decode_stage #(.DATA_W(16), .REG_ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .fe_valid(fe_valid), .fe_ir(fe_ir), .fe_npc(fe_npc),
    .mem_stall(mem_stall), .flush(flush), .sr1_data(sr1_data), .sr2_data(sr2_data),
    .agex_ld_reg_v(agex_ld_reg_v), .mem_ld_reg_v(mem_ld_reg_v), .sr_ld_reg_v(sr_ld_reg_v),
    .agex_dr_id(agex_dr_id), .mem_dr_id(mem_dr_id), .sr_dr_id(sr_dr_id),
    .cs_addr(cs_addr), .sr1_id(sr1_id), .sr2_id(sr2_id), .de_stall(de_stall),
    .de_br_stall(de_br_stall), .agex_valid(agex_valid), .agex_ir(agex_ir),
    .agex_npc(agex_npc), .agex_sr1(agex_sr1), .agex_sr2(agex_sr2), .agex_drid(agex_drid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // opcode membership sets as 16-bit masks indexed by opcode
  function automatic logic f_in(input logic [15:0] mask, input logic [3:0] op);
    return mask[op];
  endfunction
  function automatic logic f_store(input logic [15:0] ir);
    return f_in(16'h0888, ir[15:12]);
  endfunction
  function automatic logic f_uses1(input logic [15:0] ir);
    return f_in(16'h3EEE, ir[15:12]) || (ir[15:12] == 4'd4 && !ir[11]);
  endfunction
  function automatic logic f_uses2(input logic [15:0] ir);
    return f_store(ir) || (f_in(16'h0222, ir[15:12]) && !ir[5]);
  endfunction
  function automatic logic [2:0] f_sr2(input logic [15:0] ir);
    return f_store(ir) ? ir[11:9] : ir[2:0];
  endfunction
  function automatic logic [2:0] f_dr(input logic [15:0] ir);
    return (ir[15:12] == 4'd4) ? 3'd7 : ir[11:9];
  endfunction
  function automatic logic f_hit(input logic [2:0] r);
    return (agex_ld_reg_v && agex_dr_id == r) || (mem_ld_reg_v && mem_dr_id == r) ||
           (sr_ld_reg_v && sr_dr_id == r);
  endfunction
  function automatic logic f_dep();
    return m_dv && ((f_uses1(m_dir) && f_hit(m_dir[8:6])) ||
                    (f_uses2(m_dir) && f_hit(f_sr2(m_dir))));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_dv = 0; m_dir = 0; m_dnpc = 0;
    m_av = 0; m_air = 0; m_anpc = 0; m_asr1 = 0; m_asr2 = 0; m_adr = 0;
  endtask

  task automatic check_all();
    logic dep;
    dep = f_dep();
    chk("cs_addr", 32'(cs_addr), 32'({m_dir[15:12], m_dir[11], m_dir[5]}));
    chk("sr1_id", 32'(sr1_id), 32'(m_dir[8:6]));
    chk("sr2_id", 32'(sr2_id), 32'(f_sr2(m_dir)));
    chk("de_stall", 32'(de_stall), 32'(dep || mem_stall));
    chk("de_br_stall", 32'(de_br_stall), 32'(m_dv && f_in(16'h9011, m_dir[15:12])));
    chk("agex_valid", 32'(agex_valid), 32'(m_av));
    chk("agex_ir", 32'(agex_ir), 32'(m_air));
    chk("agex_npc", 32'(agex_npc), 32'(m_anpc));
    chk("agex_sr1", 32'(agex_sr1), 32'(m_asr1));
    chk("agex_sr2", 32'(agex_sr2), 32'(m_asr2));
    chk("agex_drid", 32'(agex_drid), 32'(m_adr));
  endtask

  task automatic m_update();
    logic dep;
    logic stall;
    if (!rst_n) begin
      m_reset();
    end else begin
      dep = f_dep();
      stall = dep || mem_stall;
      if (flush) m_av = 0;
      else if (!mem_stall) begin
        m_av = m_dv && !dep;
        m_air = m_dir; m_anpc = m_dnpc; m_adr = f_dr(m_dir);
        m_asr1 = sr1_data; m_asr2 = sr2_data;
      end
      if (flush) m_dv = 0;
      else if (!stall) begin
        m_dv = fe_valid; m_dir = fe_ir; m_dnpc = fe_npc;
      end
    end
  endtask

  // check model against DUT mid-cycle, then advance one clock
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic clear_hazards();
    agex_ld_reg_v = 0; mem_ld_reg_v = 0; sr_ld_reg_v = 0;
    agex_dr_id = 0; mem_dr_id = 0; sr_dr_id = 0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 0; fe_valid = 0; fe_ir = 0; fe_npc = 0; mem_stall = 0; flush = 0;
    sr1_data = 16'hA1A1; sr2_data = 16'hB2B2;
    clear_hazards();
    m_reset();

    #3;
    chk("rst_cs_addr", 32'(cs_addr), 0);
    chk("rst_agex_valid", 32'(agex_valid), 0);
    chk("rst_agex_ir", 32'(agex_ir), 0);
    @(negedge clk);
    rst_n = 1;
    cycle();

    // ADD R1,R2,#5 with no hazards
    fe_valid = 1; fe_ir = 16'h12A5; fe_npc = 16'h3002;
    cycle();
    fe_valid = 0; fe_ir = 16'h0000; fe_npc = 16'h0000;
    chk("add_imm_cs_addr", 32'(cs_addr), 32'(6'b000101));
    cycle();
    chk("add_imm_agex_ir", 32'(agex_ir), 32'h12A5);
    chk("add_imm_agex_npc", 32'(agex_npc), 32'h3002);
    chk("add_imm_agex_drid", 32'(agex_drid), 1);
    chk("add_imm_agex_valid", 32'(agex_valid), 1);

    // ADD R3,R1,R2 stalled two cycles by AGEX writing R1
    fe_valid = 1; fe_ir = 16'h1642; fe_npc = 16'h3004;
    cycle();
    fe_valid = 0; fe_ir = 16'hFFFF;
    agex_ld_reg_v = 1; agex_dr_id = 1;
    #1 chk("raw_stall_c1", 32'(de_stall), 1);
    cycle();
    chk("raw_bubble_c1", 32'(agex_valid), 0);
    chk("raw_hold_cs", 32'(cs_addr), 32'(6'b000100));
    chk("raw_stall_c2", 32'(de_stall), 1);
    cycle();
    chk("raw_bubble_c2", 32'(agex_valid), 0);
    clear_hazards();
    #1 chk("raw_release", 32'(de_stall), 0);
    cycle();
    chk("raw_issue_valid", 32'(agex_valid), 1);
    chk("raw_issue_ir", 32'(agex_ir), 32'h1642);
    chk("raw_issue_drid", 32'(agex_drid), 3);

    // STW R4,R5,#0: store reads ir[11:9] as SR2
    fe_valid = 1; fe_ir = 16'h7940; fe_npc = 16'h3006;
    cycle();
    fe_valid = 0;
    mem_ld_reg_v = 1; mem_dr_id = 4;
    #1 chk("stw_sr2_id", 32'(sr2_id), 4);
    chk("stw_stall", 32'(de_stall), 1);
    mem_dr_id = 6;
    #1 chk("stw_no_stall", 32'(de_stall), 0);
    clear_hazards();
    cycle();

    // JSR, then flush together with mem_stall
    fe_valid = 1; fe_ir = 16'h4801; fe_npc = 16'h3008;
    cycle();
    chk("jsr_br_stall", 32'(de_br_stall), 1);
    chk("jsr_cs_addr", 32'(cs_addr), 32'(6'b010010));
    cycle();
    chk("jsr_agex_drid", 32'(agex_drid), 7);
    chk("jsr_agex_valid", 32'(agex_valid), 1);
    flush = 1; mem_stall = 1;
    cycle();
    flush = 0; mem_stall = 0; fe_valid = 0;
    chk("flush_agex_valid", 32'(agex_valid), 0);
    chk("flush_de_valid", 32'(de_br_stall), 0);
    cycle();

    // mem_stall for three cycles with a valid instruction in DE
    fe_valid = 1; fe_ir = 16'h12A5; fe_npc = 16'h3010;
    cycle();
    fe_ir = 16'h5042; fe_npc = 16'h3012;
    cycle();
    fe_ir = 16'hC1C0; fe_npc = 16'h3014;
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      sr1_data = 16'(i + 7); sr2_data = 16'(i + 9);
      cycle();
      chk("mstall_agex_ir", 32'(agex_ir), 32'h12A5);
      chk("mstall_agex_valid", 32'(agex_valid), 1);
      chk("mstall_cs_addr", 32'(cs_addr), 32'(6'b010100));
    end
    mem_stall = 0;
    cycle();
    chk("mstall_release_ir", 32'(agex_ir), 32'h5042);
    chk("mstall_release_valid", 32'(agex_valid), 1);
    fe_valid = 0;
    cycle();

    // reset while ADD R1,R2,R3 sits in DE, flush during reset ignored
    fe_valid = 1; fe_ir = 16'h1283; fe_npc = 16'h3020;
    cycle();
    rst_n = 0; flush = 1;
    #1;
    m_reset();
    chk("mrst_cs_addr", 32'(cs_addr), 0);
    chk("mrst_agex_ir", 32'(agex_ir), 0);
    chk("mrst_agex_npc", 32'(agex_npc), 0);
    chk("mrst_agex_drid", 32'(agex_drid), 0);
    chk("mrst_sr_ids", 32'({sr1_id, sr2_id}), 0);
    chk("mrst_stalls", 32'({de_stall, de_br_stall, agex_valid}), 0);
    @(posedge clk);
    m_update();
    @(negedge clk);
    rst_n = 1; flush = 0;
    fe_valid = 1; fe_ir = 16'h12A5; fe_npc = 16'h3030;
    cycle();
    fe_valid = 0;
    chk("mrst_first_c1", 32'(agex_valid), 0);
    cycle();
    chk("mrst_first_c2", 32'(agex_valid), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      fe_valid = ($urandom_range(0, 3) != 0);
      fe_ir = 16'($urandom); fe_npc = 16'($urandom);
      sr1_data = 16'($urandom); sr2_data = 16'($urandom);
      mem_stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 15) == 0);
      agex_ld_reg_v = ($urandom_range(0, 2) == 0);
      mem_ld_reg_v = ($urandom_range(0, 2) == 0);
      sr_ld_reg_v = ($urandom_range(0, 2) == 0);
      agex_dr_id = 3'($urandom); mem_dr_id = 3'($urandom); sr_dr_id = 3'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
